time_msg_packer: RTL and testbench

//  Downstream consumer of the system time generator (year..msecond counters, 50 MHz, 1 ms tick).

---
 rtl/time_msg_packer_pkg.sv | 50 +++++
 rtl/time_msg_packer_ms_period_tick.sv | 28 ++
 rtl/time_msg_packer.sv | 131 +++++++++++++
 tb/tb_time_msg_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_msg_packer_pkg.sv
// rtl/time_msg_packer_pkg.sv - shared constants, types and field mux for the time message packer
package time_msg_packer_pkg;

  localparam logic [7:0] HDR0_DEFAULT = 8'hA5;
  localparam logic [7:0] HDR1_DEFAULT = 8'h5A;
  localparam int         FRAME_LEN    = 11;

  localparam logic [3:0] IDX_HDR0   = 4'd0;
  localparam logic [3:0] IDX_HDR1   = 4'd1;
  localparam logic [3:0] IDX_YEAR   = 4'd2;
  localparam logic [3:0] IDX_MONTH  = 4'd3;
  localparam logic [3:0] IDX_DAY    = 4'd4;
  localparam logic [3:0] IDX_HOUR   = 4'd5;
  localparam logic [3:0] IDX_MINUTE = 4'd6;
  localparam logic [3:0] IDX_SECOND = 4'd7;
  localparam logic [3:0] IDX_MS_HI  = 4'd8;
  localparam logic [3:0] IDX_MS_LO  = 4'd9;
  localparam logic [3:0] IDX_CSUM   = 4'(FRAME_LEN - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  typedef struct packed {
    logic [7:0]  year;
    logic [7:0]  month;
    logic [7:0]  day;
    logic [7:0]  hour;
    logic [7:0]  minute;
    logic [7:0]  second;
    logic [15:0] msecond;
  } time_snap_t;

  // Payload bytes only; headers and checksum are supplied by the caller.
  function automatic logic [7:0] snap_byte(input time_snap_t s, input logic [3:0] idx);
    case (idx)
      IDX_YEAR:   return s.year;
      IDX_MONTH:  return s.month;
      IDX_DAY:    return s.day;
      IDX_HOUR:   return s.hour;
      IDX_MINUTE: return s.minute;
      IDX_SECOND: return s.second;
      IDX_MS_HI:  return s.msecond[15:8];
      IDX_MS_LO:  return s.msecond[7:0];
      default:    return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/time_msg_packer_ms_period_tick.sv
// rtl/time_msg_packer_ms_period_tick.sv - counts millisecond edges and pulses once per period
module ms_period_tick #(
  parameter int PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ms_edge,
  output logic tick
);

  localparam logic        ENABLED = (PERIOD > 0);
  localparam logic [15:0] LAST    = (PERIOD > 0) ? 16'(PERIOD - 1) : 16'd0;

  logic [15:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (ms_edge) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
    end
  end

  // Combinational so the request lands in the same cycle as the edge that completes the period.
  assign tick = ENABLED && ms_edge && (cnt == LAST);

endmodule

// File: rtl/time_msg_packer.sv
// rtl/time_msg_packer.sv - snapshots time fields and streams an 11-byte checksummed frame
module time_msg_packer
  import time_msg_packer_pkg::*;
#(
  parameter logic [7:0] HDR0           = HDR0_DEFAULT,
  parameter logic [7:0] HDR1           = HDR1_DEFAULT,
  parameter int         AUTO_PERIOD_MS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        time_valid,
  input  logic [7:0]  year_i,
  input  logic [7:0]  month_i,
  input  logic [7:0]  day_i,
  input  logic [7:0]  hour_i,
  input  logic [7:0]  minute_i,
  input  logic [7:0]  second_i,
  input  logic [15:0] msecond_i,
  input  logic        stamp_req,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] drop_cnt
);

  state_t      state;
  logic [3:0]  idx;
  logic        pending;
  time_snap_t  snap;
  logic [7:0]  csum;
  logic [15:0] prev_ms;

  logic        ms_edge;
  logic        auto_tick;
  logic        req;
  logic        accept;
  logic [3:0]  next_idx;
  logic [7:0]  csum_next;
  logic [7:0]  next_byte;

  assign ms_edge = (msecond_i != prev_ms);

  always_ff @(posedge clk) begin
    if (!rst_n) prev_ms <= '0;
    else        prev_ms <= msecond_i;
  end

  ms_period_tick #(
    .PERIOD(AUTO_PERIOD_MS)
  ) u_ms_period_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!time_valid),
    .ms_edge (ms_edge),
    .tick    (auto_tick)
  );

  assign req    = time_valid && (stamp_req || auto_tick);
  assign accept = (state == ST_SEND) && m_valid && m_ready;
  assign busy   = (state != ST_IDLE) || pending;

  // The checksum byte is the running sum including the byte accepted this cycle.
  always_comb begin
    next_idx  = idx + 4'd1;
    csum_next = csum;
    if (idx >= IDX_YEAR && idx <= IDX_MS_LO) csum_next = csum + m_data;
    case (next_idx)
      IDX_HDR1: next_byte = HDR1;
      IDX_CSUM: next_byte = csum_next;
      default:  next_byte = snap_byte(snap, next_idx);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      pending  <= 1'b0;
      snap     <= '0;
      csum     <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req || (pending && time_valid)) begin
            snap    <= {year_i, month_i, day_i, hour_i, minute_i, second_i, msecond_i};
            pending <= req && pending;
            state   <= ST_SEND;
            idx     <= IDX_HDR0;
            csum    <= '0;
            m_data  <= HDR0;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
          end else if (!time_valid) begin
            pending <= 1'b0;
          end
        end
        ST_SEND: begin
          // One request may wait behind the running frame; anything beyond that is dropped.
          if (req) begin
            if (!pending)                 pending  <= 1'b1;
            else if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          end else if (!time_valid) begin
            pending <= 1'b0;
          end
          if (accept) begin
            csum <= csum_next;
            if (idx == IDX_CSUM) begin
              state   <= ST_IDLE;
              idx     <= '0;
              m_data  <= '0;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
            end else begin
              idx    <= next_idx;
              m_data <= next_byte;
              m_last <= (next_idx == IDX_CSUM);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_msg_packer.sv
// tb/tb_time_msg_packer.sv - scoreboard bench for time_msg_packer with table vectors and corner sequences
module tb_time_msg_packer;
  import time_msg_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        time_valid = 1'b1;
  logic [7:0]  year_i = '0, month_i = '0, day_i = '0, hour_i = '0, minute_i = '0, second_i = '0;
  logic [15:0] msecond_i = '0;
  logic        stamp_req = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_last, busy;
  logic        m_ready = 1'b1;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int bytes_seen = 0;
  int frames_seen = 0;
  bit rand_ready = 1'b0;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0]  y, mo, d, h, mi, s;
    logic [15:0] ms;
    logic [7:0]  csum;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  time_msg_packer #(.AUTO_PERIOD_MS(10)) dut (
    .clk(clk), .rst_n(rst_n), .time_valid(time_valid),
    .year_i(year_i), .month_i(month_i), .day_i(day_i), .hour_i(hour_i),
    .minute_i(minute_i), .second_i(second_i), .msecond_i(msecond_i),
    .stamp_req(stamp_req), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] calc_csum(input vec_t v);
    return 8'(v.y + v.mo + v.d + v.h + v.mi + v.s + v.ms[15:8] + v.ms[7:0]);
  endfunction

  task automatic set_fields(input vec_t v);
    year_i = v.y; month_i = v.mo; day_i = v.d; hour_i = v.h;
    minute_i = v.mi; second_i = v.s; msecond_i = v.ms;
  endtask

  task automatic push_frame(input vec_t v);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b0, v.y});
    exp_q.push_back({1'b0, v.mo});
    exp_q.push_back({1'b0, v.d});
    exp_q.push_back({1'b0, v.h});
    exp_q.push_back({1'b0, v.mi});
    exp_q.push_back({1'b0, v.s});
    exp_q.push_back({1'b0, v.ms[15:8]});
    exp_q.push_back({1'b0, v.ms[7:0]});
    exp_q.push_back({1'b1, v.csum});
  endtask

  task automatic pulse_req();
    stamp_req = 1'b1;
    cyc();
    stamp_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while ((busy || m_valid || exp_q.size() != 0) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, %0d bytes still expected", name, n, exp_q.size());
    end
    cyc();
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Scoreboard side: every accepted byte is popped and compared; stalled bytes must hold.
  logic       stall_d = 1'b0;
  logic [8:0] stall_v = '0;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      stall_d = 1'b0;
    end else begin
      if (stall_d) check("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, stall_v}));
      if (m_valid && m_ready) begin
        bytes_seen++;
        if (m_last) frames_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %h expected none", {m_last, m_data});
        end else begin
          check("stream_byte", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
        end
      end
      stall_d = m_valid && !m_ready;
      stall_v = {m_last, m_data};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, b0, n;
    vec_t v;
    vecs[0] = '{8'h07, 8'h03, 8'h0A, 8'h0C, 8'h1E, 8'h2D, 16'd500,  8'h60};
    vecs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'd0,    8'h00};
    vecs[2] = '{8'hFF, 8'h0B, 8'h1E, 8'h17, 8'h3B, 8'h3B, 16'd999,  8'h9F};
    vecs[3] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h8080, 8'h80};
    vecs[4] = '{8'h12, 8'h05, 8'h10, 8'h08, 8'h2A, 8'h01, 16'h0123, 8'h7E};

    repeat (2) cyc();
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Worked example with explicit request latency.
    set_fields(vecs[0]);
    push_frame(vecs[0]);
    stamp_req = 1'b1;
    @(negedge clk);
    check("valid_before_req_edge", 32'(m_valid), 32'd0);
    cyc();
    stamp_req = 1'b0;
    @(negedge clk);
    check("latency_valid", 32'(m_valid), 32'd1);
    check("latency_hdr0", 32'(m_data), 32'hA5);
    wait_done("frame_v0", 200);

    for (int i = 0; i < 5; i++) begin
      set_fields(vecs[i]);
      push_frame(vecs[i]);
      pulse_req();
      wait_done("table_frame", 200);
    end

    // Random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(vecs[i % 2 == 0 ? 0 : 2]);
      push_frame(vecs[i % 2 == 0 ? 0 : 2]);
      pulse_req();
      wait_done("stall_frame", 500);
    end
    rand_ready = 1'b0;

    // Three requests in one frame: one runs, one waits, one drops.
    f0 = frames_seen;
    set_fields(vecs[4]);
    push_frame(vecs[4]);
    push_frame(vecs[4]);
    pulse_req();
    cyc();
    pulse_req();
    cyc();
    pulse_req();
    wait_done("overflow_frames", 300);
    check("overflow_frames", 32'(frames_seen - f0), 32'd2);
    check("overflow_drop_cnt", 32'(drop_cnt), 32'd1);

    // time_valid falling mid-frame discards the pending request.
    f0 = frames_seen;
    set_fields(vecs[1]);
    push_frame(vecs[1]);
    pulse_req();
    pulse_req();
    time_valid = 1'b0;
    cyc();
    check("tv_low_frame_busy", 32'(busy), 32'd1);
    wait_done("tv_low_frame", 200);
    check("tv_low_frames", 32'(frames_seen - f0), 32'd1);
    pulse_req();
    repeat (3) cyc();
    check("tv_low_req_ignored", 32'(busy), 32'd0);
    check("tv_low_no_drop", 32'(drop_cnt), 32'd1);
    time_valid = 1'b1;

    // Reset in the middle of a frame with a pending request and a drop recorded.
    set_fields(vecs[2]);
    push_frame(vecs[2]);
    pulse_req();
    pulse_req();
    pulse_req();
    b0 = bytes_seen;
    n = 0;
    while (bytes_seen - b0 < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_drop_cnt", 32'(drop_cnt), 32'd2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    f0 = frames_seen;
    push_frame(vecs[2]);
    pulse_req();
    wait_done("post_reset_frame", 200);
    check("post_reset_frames", 32'(frames_seen - f0), 32'd1);

    // Upstream keeps counting while the snapshot is streamed.
    set_fields(vecs[3]);
    push_frame(vecs[3]);
    pulse_req();
    for (int k = 0; k < 6; k++) begin
      year_i = 8'($urandom); month_i = 8'($urandom); day_i = 8'($urandom);
      hour_i = 8'($urandom); minute_i = 8'($urandom); second_i = 8'($urandom);
      msecond_i = 16'(k + 1);
      cyc();
    end
    wait_done("snapshot_frame", 200);

    // Auto-stamp every 10 millisecond edges, then silence while time_valid is low.
    v = vecs[4];
    v.ms = 16'd0;
    set_fields(v);
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    f0 = frames_seen;
    for (int e = 1; e <= 30; e++) begin
      msecond_i = 16'(e);
      if (e % 10 == 0) begin
        v.ms = 16'(e);
        v.csum = calc_csum(v);
        push_frame(v);
      end
      repeat (20) cyc();
    end
    wait_done("auto_frames", 200);
    check("auto_frame_count", 32'(frames_seen - f0), 32'd3);
    time_valid = 1'b0;
    f0 = frames_seen;
    for (int e = 31; e <= 60; e++) begin
      msecond_i = 16'(e);
      repeat (20) cyc();
    end
    check("auto_tv_low_frames", 32'(frames_seen - f0), 32'd0);
    check("auto_tv_low_busy", 32'(busy), 32'd0);
    time_valid = 1'b1;

    repeat (5) cyc();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
